prog_frame_loader: RTL and testbench



---
 rtl/prog_frame_loader_pkg.sv | 11 +
 rtl/prog_frame_buffer.sv | 37 +++
 rtl/prog_frame_loader.sv | 126 ++++++++++++
 tb/tb_prog_frame_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_frame_loader_pkg.sv
// Shared constants for the program loader and the scheduler that consumes its frame buffer.
package prog_frame_loader_pkg;

    localparam int FRAME_W    = 16;
    localparam int PROG_DEPTH = 1024;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/prog_frame_buffer.sv
// DEPTH x WIDTH frame register array with one write port, a clear-all-except-addr
// strobe and a flat read-out bus.
module prog_frame_buffer
    import prog_frame_loader_pkg::*;
#(
    parameter int DEPTH = PROG_DEPTH,
    parameter int WIDTH = FRAME_W,
    parameter int PTR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic                     clr_i,
    input  logic [PTR_W-1:0]         addr_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [DEPTH*WIDTH-1:0]   frames_o
);

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        localparam logic [PTR_W-1:0] IDX = PTR_W'(k);
        logic [WIDTH-1:0] slot_q;

        // Clear and write are exclusive per slot: clear never touches the addressed slot.
        always_ff @(posedge clk) begin
            if (reset) begin
                slot_q <= '0;
            end else if (we_i && (addr_i == IDX)) begin
                slot_q <= data_i;
            end else if (clr_i) begin
                slot_q <= '0;
            end
        end

        assign frames_o[k*WIDTH +: WIDTH] = slot_q;
    end

endmodule

// File: rtl/prog_frame_loader.sv
// Assembles host instruction frames into the scheduler's flat frame buffer and
// strobes prog_loading for one cycle once a whole program is in place.
module prog_frame_loader
    import prog_frame_loader_pkg::*;
#(
    parameter int DEPTH = PROG_DEPTH,
    parameter int WIDTH = FRAME_W,
    parameter int PTR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_valid,
    input  logic [WIDTH-1:0]         host_data,
    input  logic                     host_last,
    input  logic                     host_abort,
    output logic                     host_ready,
    output logic                     prog_loading,
    output logic [DEPTH*WIDTH-1:0]   data_frames_out,
    output logic [PTR_W:0]           prog_len,
    output logic                     overflow,
    output logic                     busy
);

    localparam logic [PTR_W:0] ONE       = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] LAST_SLOT = (PTR_W+1)'(DEPTH - 1);

    logic [1:0]       state_q, state_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   len_q, len_d;
    logic             ovf_q, ovf_d;

    logic             buf_we;
    logic             buf_clr;
    logic [PTR_W-1:0] buf_addr;
    logic [WIDTH-1:0] buf_data;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        buf_we   = 1'b0;
        buf_clr  = 1'b0;
        buf_addr = wr_ptr_q[PTR_W-1:0];
        buf_data = host_data;
        case (state_q)
            ST_IDLE: begin
                if (host_valid) begin
                    buf_we   = 1'b1;
                    buf_clr  = 1'b1;
                    buf_addr = '0;
                    wr_ptr_d = ONE;
                    ovf_d    = 1'b0;
                    if (host_last) begin
                        state_d = ST_COMMIT;
                        len_d   = ONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (host_abort) begin
                    // Abort reuses the clear path: write zero to slot 0, clear the rest.
                    buf_we   = 1'b1;
                    buf_clr  = 1'b1;
                    buf_addr = '0;
                    buf_data = '0;
                    wr_ptr_d = '0;
                    state_d  = ST_IDLE;
                end else if (host_valid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    if (host_last || (wr_ptr_q == LAST_SLOT)) begin
                        state_d = ST_COMMIT;
                        len_d   = wr_ptr_q + ONE;
                        ovf_d   = !host_last;
                    end
                end
            end
            ST_COMMIT: begin
                state_d  = ST_IDLE;
                wr_ptr_d = '0;
            end
            default: begin
                state_d  = ST_IDLE;
                wr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
        end
    end

    prog_frame_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .we_i     (buf_we),
        .clr_i    (buf_clr),
        .addr_i   (buf_addr),
        .data_i   (buf_data),
        .frames_o (data_frames_out)
    );

    assign host_ready   = (state_q != ST_COMMIT);
    assign prog_loading = (state_q == ST_COMMIT);
    assign busy         = (state_q != ST_IDLE);
    assign prog_len     = len_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_prog_frame_loader.sv
// Directed and randomized program loads checked every cycle against a slot-array model.
module tb_prog_frame_loader;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 16;
    localparam int PTR_W = 10;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   host_valid;
    logic [WIDTH-1:0]       host_data;
    logic                   host_last;
    logic                   host_abort;
    logic                   host_ready;
    logic                   prog_loading;
    logic [DEPTH*WIDTH-1:0] data_frames_out;
    logic [PTR_W:0]         prog_len;
    logic                   overflow;
    logic                   busy;

    prog_frame_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .host_valid      (host_valid),
        .host_data       (host_data),
        .host_last       (host_last),
        .host_abort      (host_abort),
        .host_ready      (host_ready),
        .prog_loading    (prog_loading),
        .data_frames_out (data_frames_out),
        .prog_len        (prog_len),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Reference model: program contents as an array, plus a frame count and commit flag.
    logic [WIDTH-1:0]       mem [DEPTH];
    int                     cnt;
    bit                     in_prog;
    bit                     pend;
    int                     exp_len;
    bit                     exp_ovf;
    logic [DEPTH*WIDTH-1:0] exp_flat;

    int checks = 0;
    int errors = 0;

    task automatic model_edge();
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = '0;
            cnt = 0; in_prog = 0; pend = 0; exp_len = 0; exp_ovf = 0;
        end else if (pend) begin
            pend = 0;
        end else if (in_prog && host_abort) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = '0;
            cnt = 0; in_prog = 0;
        end else if (host_valid) begin
            if (!in_prog) begin
                for (int k = 0; k < DEPTH; k++) mem[k] = '0;
                cnt = 0; in_prog = 1; exp_ovf = 0;
            end
            mem[cnt] = host_data;
            cnt++;
            if (host_last || cnt == DEPTH) begin
                exp_ovf = !host_last;
                exp_len = cnt;
                pend = 1; in_prog = 0; cnt = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < DEPTH; k++) exp_flat[k*WIDTH +: WIDTH] = mem[k];
        chk("prog_loading", 32'(prog_loading), 32'(pend));
        chk("host_ready",   32'(host_ready),   32'(!pend));
        chk("busy",         32'(busy),         32'(in_prog || pend));
        chk("prog_len",     32'(prog_len),     32'(exp_len));
        chk("overflow",     32'(overflow),     32'(exp_ovf));
        checks++;
        assert (data_frames_out === exp_flat) else begin
            errors++;
            for (int k = 0; k < DEPTH; k++)
                if (data_frames_out[k*WIDTH +: WIDTH] !== mem[k]) begin
                    $error("FAIL slot[%0d]: observed=0x%0h expected=0x%0h",
                           k, data_frames_out[k*WIDTH +: WIDTH], mem[k]);
                    break;
                end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    // Present a frame and keep it up until the model says it was taken (bounded retries).
    task automatic frame(input logic [WIDTH-1:0] d, input logic l);
        bit was_pend;
        bit taken = 0;
        for (int t = 0; t < 4 && !taken; t++) begin
            host_valid = 1'b1; host_data = d; host_last = l;
            was_pend = pend;
            tick();
            taken = !was_pend;
        end
        if (!taken) begin
            checks++; errors++;
            $display("FAIL frame_accept_timeout: observed=not_accepted expected=accepted");
        end
    endtask

    task automatic idle(input int n);
        host_valid = 1'b0; host_last = 1'b0; host_abort = 1'b0;
        host_data = WIDTH'($urandom);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; host_valid = 1'b0; host_data = '0; host_last = 1'b0; host_abort = 1'b0;
        cnt = 0; in_prog = 0; pend = 0; exp_len = 0; exp_ovf = 0;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        tick();
        tick();
        reset = 1'b0;
        idle(1);

        // Three-frame program
        frame(16'h1111, 0); frame(16'h2222, 0); frame(16'h3333, 1);
        chk("t1_len", 32'(prog_len), 32'd3);
        idle(2);

        // Single frame straight to commit
        frame(16'hABCD, 1);
        chk("t2_slot0", 32'(data_frames_out[15:0]), 32'hABCD);
        idle(1);

        // Five-frame program followed by a two-frame program
        for (int i = 0; i < 5; i++) frame(WIDTH'($urandom), i == 4);
        idle(2);
        frame(16'h0F0F, 0);
        chk("t3_slot2_cleared", 32'(data_frames_out[2*WIDTH +: WIDTH]), 32'd0);
        frame(16'hF0F0, 1);
        chk("t3_len", 32'(prog_len), 32'd2);
        idle(1);

        // Full buffer without host_last, valid held through the commit cycle
        for (int i = 0; i < DEPTH; i++) frame(WIDTH'($urandom), 0);
        chk("t4_len", 32'(prog_len), 32'(DEPTH));
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_ready_low", 32'(host_ready), 32'd0);
        frame(16'h5A5A, 0);
        chk("t4_new_slot0", 32'(data_frames_out[15:0]), 32'h5A5A);
        frame(16'h6B6B, 1);
        idle(1);

        // Abort together with a valid frame
        for (int i = 0; i < 4; i++) frame(WIDTH'($urandom), 0);
        host_abort = 1'b1; host_valid = 1'b1; host_data = 16'hDEAD; host_last = 1'b0;
        tick();
        chk("t5_len_kept", 32'(prog_len), 32'd2);
        idle(3);

        // Reset in the middle of a four-frame program
        frame(16'h1234, 0); frame(16'h5678, 0);
        host_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_len_reset", 32'(prog_len), 32'd0);
        idle(2);
        frame(16'h9999, 1);
        chk("t6_fresh_len", 32'(prog_len), 32'd1);
        idle(1);

        // Randomized programs with gaps and occasional aborts
        for (int p = 0; p < 8; p++) begin
            int n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                if (p % 3 == 2 && i == n / 2 && i > 0) begin
                    host_abort = 1'b1; host_valid = $urandom_range(0, 1) == 1;
                    host_last = 1'b0;
                    tick();
                    host_abort = 1'b0;
                    break;
                end
                frame(WIDTH'($urandom), i == n - 1);
            end
            idle($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
